// File: rtl/imem_loadable_if.sv
// -----------------------------------------------------------------------------
// imem_loadable_if
// Bundles the fetch port and the byte-serial download port of imem_loadable.
//
// Handshake: a download byte transfers on a rising edge where iByteValid and
// oByteReady are both 1. iByte must be stable whenever iByteValid is 1.
// oByteReady depends only on internal state, never combinationally on
// iByteValid. iLoadStart / iLoadEnd are single-cycle pulses.
//
// Modports:
//   master - processor fetch stage plus host byte source (drives the i* signals)
//   slave  - the memory itself (drives the o* signals)
//
// Signals:
//   iAddress      fetch word address
//   oInstruction  fetched word, registered, one cycle latency
//   iLoadStart    pulse: begin a download at word 0
//   iLoadEnd      pulse: finish the download
//   iByte         download byte, most significant byte of each word first
//   iByteValid    iByte is valid this cycle
//   oByteReady    memory accepts a byte this cycle
//   oBusy         memory not fetchable, processor must stall
//   oLoadCount    words written in the current/last download
//   oLoadOverflow sticky: the download ran past the end of memory
//   oState        FSM state, for observation only
//   oChecksum     running byte sum of the download (IMEM_CHECKSUM_EN only)
//
// Optional feature macro: IMEM_CHECKSUM_EN adds oChecksum.
// -----------------------------------------------------------------------------
interface imem_loadable_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  iLoadStart;
  logic                  iLoadEnd;
  logic [7:0]            iByte;
  logic                  iByteValid;
  logic                  oByteReady;
  logic                  oBusy;
  logic [ADDR_WIDTH:0]   oLoadCount;
  logic                  oLoadOverflow;
  logic [1:0]            oState;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]            oChecksum;

  modport master (
    output iAddress, iLoadStart, iLoadEnd, iByte, iByteValid,
    input  oInstruction, oByteReady, oBusy, oLoadCount, oLoadOverflow,
           oState, oChecksum
  );
  modport slave (
    input  iAddress, iLoadStart, iLoadEnd, iByte, iByteValid,
    output oInstruction, oByteReady, oBusy, oLoadCount, oLoadOverflow,
           oState, oChecksum
  );
`else
  modport master (
    output iAddress, iLoadStart, iLoadEnd, iByte, iByteValid,
    input  oInstruction, oByteReady, oBusy, oLoadCount, oLoadOverflow, oState
  );
  modport slave (
    input  iAddress, iLoadStart, iLoadEnd, iByte, iByteValid,
    output oInstruction, oByteReady, oBusy, oLoadCount, oLoadOverflow, oState
  );
`endif
endinterface

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Writable synchronous instruction memory for the soft processor. After reset
// every word is filled with NOP_WORD (one word per cycle), then the memory is
// fetchable. A host can download a new program byte-serially; bytes are packed
// most-significant first into words of ceil(DATA_WIDTH/8) bytes.
//
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - synchronous, active-high
//   bus    - imem_loadable_if.slave (fetch port, download port, status)
//
// FSM: CLEAR (fill with NOP) -> RUN (fetchable) <-> LOAD (downloading).
//
// Optional feature macro: IMEM_CHECKSUM_EN adds bus.oChecksum, an 8-bit sum of
// every byte accepted during a download, cleared on iLoadStart.
// -----------------------------------------------------------------------------
module imem_loadable #(
  parameter int                    DATA_WIDTH = 28,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 28'h0000FA0
) (
  input logic            Clock,
  input logic            Reset,
  imem_loadable_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int SW    = BPW * 8;
  localparam int CW    = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_instr;
  logic [SW-9:0]         r_shift;     // the BPW-1 bytes received before the last one
  logic [CW-1:0]         r_byte_cnt;
  logic [ADDR_WIDTH:0]   r_count;     // also the write address while not full
  logic                  r_ovf;
  logic                  w_busy;
  logic                  w_ready;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_word_done;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_CLEAR;
    else       r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_ptr == {ADDR_WIDTH{1'b1}}) w_next_state = S_RUN;
      S_RUN:   if (bus.iLoadStart) w_next_state = S_LOAD;
      S_LOAD:  if (bus.iLoadEnd) w_next_state = S_RUN;
      default: w_next_state = S_CLEAR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy  = (r_state != S_RUN);
    w_ready = (r_state == S_LOAD);
  end

  // ---------------- download datapath control ----------------
  always_comb begin
    // iLoadEnd has priority over iLoadStart while loading.
    w_start     = ((r_state == S_RUN) & bus.iLoadStart) |
                  (w_ready & bus.iLoadStart & ~bus.iLoadEnd);
    // A byte arriving together with either pulse is dropped.
    w_accept    = w_ready & bus.iByteValid & ~bus.iLoadEnd & ~bus.iLoadStart;
    w_word_done = w_accept & (r_byte_cnt == CW'(BPW - 1));
    // Once r_count reaches DEPTH its MSB is set and further words are dropped.
    w_we        = ~Reset & ((r_state == S_CLEAR) | (w_word_done & ~r_count[ADDR_WIDTH]));
    w_waddr     = (r_state == S_CLEAR) ? r_clr_ptr : r_count[ADDR_WIDTH-1:0];
    // Truncation discards the excess top bits of the first byte.
    w_wdata     = (r_state == S_CLEAR) ? NOP_WORD : DATA_WIDTH'({r_shift, bus.iByte});
  end

  // Storage has no reset; CLEAR overwrites every word before the first fetch.
  always_ff @(posedge Clock) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_clr_ptr  <= '0;
      r_instr    <= NOP_WORD;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_instr <= (r_state == S_RUN) ? r_mem[bus.iAddress] : NOP_WORD;
      // Wraps back to 0 on the RUN entry edge, ready for the next reset.
      if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
      if (w_start) begin
        r_byte_cnt <= '0;
        r_count    <= '0;
        r_ovf      <= 1'b0;
      end else if (w_accept) begin
        r_shift <= (SW - 8)'({r_shift, bus.iByte});
        if (w_word_done) begin
          r_byte_cnt <= '0;
          if (r_count[ADDR_WIDTH]) r_ovf   <= 1'b1;
          else                     r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        end else begin
          r_byte_cnt <= r_byte_cnt + CW'(1);
        end
      end
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] r_chk;
  always_ff @(posedge Clock) begin
    if (Reset)         r_chk <= 8'h00;
    else if (w_start)  r_chk <= 8'h00;
    else if (w_accept) r_chk <= r_chk + bus.iByte;
  end
  assign bus.oChecksum = r_chk;
`endif

  assign bus.oInstruction  = r_instr;
  assign bus.oByteReady    = w_ready;
  assign bus.oBusy         = w_busy;
  assign bus.oLoadCount    = r_count;
  assign bus.oLoadOverflow = r_ovf;
  assign bus.oState        = r_state;
endmodule

// File: tb/tb_imem_loadable.sv
module tb_imem_loadable;
  localparam logic [27:0] NOP = 28'h0000FA0;
  localparam int EW = 48;  // {instr 28, busy, ready, count 9, ovf, checksum 8}
  localparam int M_CLEAR = 0, M_RUN = 1, M_LOAD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus shared by both DUTs ----------------
  logic       st = 1'b0, en = 1'b0, bv = 1'b0;
  logic [7:0] by = 8'h00, addr = 8'h00;

  imem_loadable_if #(.DATA_WIDTH(28), .ADDR_WIDTH(8)) bus_big ();
  imem_loadable_if #(.DATA_WIDTH(28), .ADDR_WIDTH(2)) bus_small ();

  assign bus_big.iAddress     = addr;
  assign bus_big.iLoadStart   = st;
  assign bus_big.iLoadEnd     = en;
  assign bus_big.iByte        = by;
  assign bus_big.iByteValid   = bv;
  assign bus_small.iAddress   = addr[1:0];
  assign bus_small.iLoadStart = st;
  assign bus_small.iLoadEnd   = en;
  assign bus_small.iByte      = by;
  assign bus_small.iByteValid = bv;

  imem_loadable #(.ADDR_WIDTH(8)) u_big   (.Clock(clk), .Reset(rst), .bus(bus_big));
  imem_loadable #(.ADDR_WIDTH(2)) u_small (.Clock(clk), .Reset(rst), .bus(bus_small));

  // ---------------- reference model (index 0: 256 words, 1: 4 words) ----------------
  logic [27:0]      m_mem [2][256];
  int               m_mode [2];
  int               m_left [2];
  logic [27:0]      m_instr [2];
  int               m_cnt [2];
  bit               m_ovf [2];
  int               m_chk [2];
  int               m_part_n [2];
  longint unsigned  m_part [2];

  function automatic int depth_of(int d);
    return (d == 0) ? 256 : 4;
  endfunction

  function automatic void model_reset_load(int d);
    m_part_n[d] = 0; m_part[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_chk[d] = 0;
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      int dep;
      dep = depth_of(d);
      if (rst) begin
        m_mode[d] = M_CLEAR; m_left[d] = dep; m_instr[d] = NOP;
        model_reset_load(d);
      end else begin
        m_instr[d] = (m_mode[d] == M_RUN) ? m_mem[d][int'(addr) % dep] : NOP;
        case (m_mode[d])
          M_CLEAR: begin
            m_mem[d][dep - m_left[d]] = NOP;
            m_left[d]--;
            if (m_left[d] == 0) m_mode[d] = M_RUN;
          end
          M_RUN: if (st) begin m_mode[d] = M_LOAD; model_reset_load(d); end
          default: begin
            if (en) m_mode[d] = M_RUN;
            else if (st) model_reset_load(d);
            else if (bv) begin
              m_chk[d]  = (m_chk[d] + int'(by)) % 256;
              m_part[d] = m_part[d] * 256 + longint'(by);
              m_part_n[d]++;
              if (m_part_n[d] == 4) begin
                if (m_cnt[d] < dep) begin
                  m_mem[d][m_cnt[d]] = 28'(m_part[d] % (64'd1 << 28));
                  m_cnt[d]++;
                end else m_ovf[d] = 1'b1;
                m_part_n[d] = 0; m_part[d] = 0;
              end
            end
          end
        endcase
      end
    end
  endfunction

  function automatic logic [EW-1:0] pack_exp(int d);
    logic [7:0] c;
`ifdef IMEM_CHECKSUM_EN
    c = 8'(m_chk[d]);
`else
    c = 8'h00;
`endif
    return {m_instr[d], m_mode[d] != M_RUN, m_mode[d] == M_LOAD, 9'(m_cnt[d]), m_ovf[d], c};
  endfunction

  // ---------------- scoreboard ----------------
  logic [2*EW-1:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2*EW-1:0] e;
      logic [EW-1:0]   a_big, a_small;
      logic [7:0]      c_big, c_small;
`ifdef IMEM_CHECKSUM_EN
      c_big = bus_big.oChecksum; c_small = bus_small.oChecksum;
`else
      c_big = 8'h00; c_small = 8'h00;
`endif
      e = exp_q.pop_front();
      a_big   = {bus_big.oInstruction, bus_big.oBusy, bus_big.oByteReady,
                 bus_big.oLoadCount, bus_big.oLoadOverflow, c_big};
      a_small = {bus_small.oInstruction, bus_small.oBusy, bus_small.oByteReady,
                 6'b0, bus_small.oLoadCount, bus_small.oLoadOverflow, c_small};
      n_vec += 2;
      if (a_big !== e[2*EW-1:EW]) begin
        n_err++;
        $display("FAIL big @%0t: got %h want %h (instr|busy|rdy|cnt|ovf|chk)", $time, a_big, e[2*EW-1:EW]);
      end
      if (a_small !== e[EW-1:0]) begin
        n_err++;
        $display("FAIL small @%0t: got %h want %h (instr|busy|rdy|cnt|ovf|chk)", $time, a_small, e[EW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back({pack_exp(0), pack_exp(1)});
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      st = 0; en = 0; bv = 0;
      by = 8'($urandom); addr = 8'($urandom_range(0, 255));
      tick();
    end
  endtask

  task automatic pulse_start();
    st = 1; en = 0; bv = 0; tick(); st = 0;
  endtask

  task automatic pulse_end();
    st = 0; en = 1; bv = 0; tick(); en = 0;
  endtask

  task automatic send_byte(logic [7:0] b);
    st = 0; en = 0; bv = 1; by = b; tick(); bv = 0;
  endtask

  task automatic read_addr(logic [7:0] a);
    st = 0; en = 0; bv = 0; addr = a; tick(); tick();
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (m_mode[0] != M_RUN && n < 400) begin idle(1); n++; end
    n_vec++;
    if (m_mode[0] != M_RUN) begin
      n_err++;
      $display("FAIL clear_timeout: still busy after %0d cycles, want idle", n);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] words [8];
    words = '{8'h00, 8'hA1, 8'h23, 8'h45, 8'h0F, 8'hFF, 8'hFF, 8'hFF};
    rst = 1; tick(); rst = 0;
    wait_run();
    idle(10);

    // two known words, then fetch them
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(words[i]);
    pulse_end();
    for (int a = 0; a < 4; a++) read_addr(8'(a));

    // valid with gaps
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      st = 0; en = 0; bv = (i != 1 && i != 4); by = 8'($urandom); tick();
    end
    bv = 0;
    pulse_end();
    read_addr(8'd0);

    // five words: the 4-word instance overflows
    pulse_start();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom));
    pulse_end();
    for (int a = 0; a < 6; a++) read_addr(8'(a));

    // start and end together after two bytes
    pulse_start();
    send_byte(8'h11); send_byte(8'h22);
    st = 1; en = 1; bv = 0; tick(); st = 0; en = 0;
    idle(3);

    // checksum wrap: 01 + 02 + FF
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF);
    pulse_end();
    idle(2);

    // reset in the middle of a download
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    rst = 1; tick(); rst = 0;
    wait_run();
    for (int a = 0; a < 5; a++) read_addr(8'(a * 3));

    // randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      idle($urandom_range(0, 4));
      pulse_start();
      for (int i = 0; i < int'($urandom_range(0, 22)); i++) begin
        st = ($urandom_range(0, 25) == 0); en = 0;
        bv = ($urandom_range(0, 3) != 0); by = 8'($urandom);
        addr = 8'($urandom);
        tick();
      end
      st = ($urandom_range(0, 3) == 0); en = 1; bv = $urandom_range(0, 1); by = 8'($urandom);
      tick();
      st = 0; en = 0; bv = 0;
      for (int i = 0; i < 6; i++) begin
        addr = 8'($urandom_range(0, 7));
        en = ($urandom_range(0, 5) == 0); bv = $urandom_range(0, 1);
        tick();
      end
      en = 0; bv = 0;
      if (ep == 20) begin
        rst = 1; tick(); rst = 0;
        wait_run();
      end
    end
    idle(4);

    @(negedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, writable successor of the fixed instruction ROM.
- Synchronous instruction memory for the soft processor, clocked and width/depth-parametrised.
- Cleared to NOP after reset; new programs are downloaded byte-serially over a valid/ready port, so the VGA drawing routines need no resynthesis.
- Sits between the processor's fetch stage (iAddress/oInstruction) and a host byte source (UART receiver or debug bridge).

Parameters:
- DATA_WIDTH, 28, instruction word width in bits.
- ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH.
- NOP_WORD, 28'h0000FA0, fill word written by clear; also the value returned while busy.

Ports:
- Clock  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- iAddress  input  ADDR_WIDTH  fetch word address.
- oInstruction  output  DATA_WIDTH  fetched word, registered.
- iLoadStart  input  1  one-cycle pulse: begin download at word 0.
- iLoadEnd  input  1  one-cycle pulse: finish download.
- iByte  input  8  download data byte.
- iByteValid  input  1  iByte valid this cycle.
- oByteReady  output  1  block accepts a byte this cycle.
- oBusy  output  1  memory not fetchable; processor must stall.
- oLoadCount  output  ADDR_WIDTH+1  words written in the current/last download.
- oLoadOverflow  output  1  download exceeded DEPTH words (sticky until next iLoadStart).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: oInstruction=NOP_WORD, oByteReady=0, oBusy=1, oLoadCount=0, oLoadOverflow=0. State=CLEAR, clear pointer=0.
- BPW = ceil(DATA_WIDTH/8); 4 at default.
- FSM states and transitions:
  - CLEAR: writes NOP_WORD to mem[ptr] each cycle, ptr++. After writing DEPTH-1, goes to RUN. Takes exactly DEPTH cycles. oBusy=1 throughout; load pulses ignored.
  - RUN: oBusy=0, oByteReady=0. iLoadStart -> LOAD with wptr=0, byte count=0, oLoadCount=0, oLoadOverflow=0. iLoadEnd ignored.
  - LOAD: oBusy=1, oByteReady=1.
    - A byte transfers when iByteValid & oByteReady.
    - Bytes assemble MSB-first into a BPW*8 shift register. On the BPW-th byte, mem[wptr] <= low DATA_WIDTH bits, i.e. excess top bits of the first byte are discarded.
    - Same edge as the write: wptr++, oLoadCount++.
    - iLoadEnd -> RUN; any partial word is discarded and memory is unchanged.
    - iLoadStart in LOAD restarts: wptr=0, partial word discarded, counters cleared.
    - iLoadStart and iLoadEnd in the same cycle: iLoadEnd wins.
    - A byte accepted in the same cycle as iLoadEnd is discarded.
- Overflow: when oLoadCount==DEPTH, further completed words are not written, oLoadOverflow=1, bytes are still accepted (oByteReady=1) and dropped. No wrap-around.
- Read:
  - oInstruction <= mem[iAddress] on every edge in RUN; latency is one cycle.
  - In CLEAR/LOAD, oInstruction <= NOP_WORD.
  - First valid fetch data appears the cycle after the RUN entry edge.
- Reset mid-LOAD or mid-CLEAR: abandons the operation and returns to CLEAR; the full memory is re-cleared.

Optional Feature:
- Macro IMEM_CHECKSUM_EN.
- Defined:
  - Adds output oChecksum [7:0], reset 0.
  - Cleared on iLoadStart.
  - On every accepted byte in LOAD: oChecksum <= oChecksum + iByte (mod 256), including bytes dropped during overflow and bytes of discarded partial words.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset held 1 cycle then released, DEPTH=256 -> oBusy=1 for exactly 256 cycles, then 0. Any address reads 28'h0000FA0 one cycle after presentation.
- iLoadStart, then bytes 00 A1 23 45, 0F FF FF FF, then iLoadEnd -> oLoadCount=2, oBusy returns to 0. Addr 0 reads 28'h0A12345, addr 1 reads 28'hFFFFFFF, addr 2 reads NOP_WORD.
- iByteValid held with gaps (valid 1,0,1,1,0,1) -> only the 4 valid bytes form one word, and oLoadCount increments once, on the 4th accepted byte.
- ADDR_WIDTH=2, send 5 full words -> words 0-3 stored, oLoadOverflow=1, oLoadCount=4, word 4 not written, word 0 unchanged.
- iLoadStart, 6 bytes, then Reset asserted -> 4-cycle clear, all locations read NOP_WORD, oLoadCount=0. With IMEM_CHECKSUM_EN, bytes 01 02 FF -> oChecksum=8'h02.
- iLoadStart and iLoadEnd in the same cycle during LOAD after 2 bytes -> state RUN, no write, oLoadCount unchanged.
